// File: rtl/r6_threshold_if.sv
// Signal bundle for the R6 adaptive-threshold stage.
// The master side drives the window stream; the slave side returns the binarized pixels.
interface r6_threshold_if;
  logic              start_i;
  logic signed [7:0] offset_i;
  logic              valid_i;
  logic [15:0]       sum_i;
  logic [7:0]        center_i;
  logic [7:0]        pixel_o;
  logic              valid_o;
  logic              eol_o;
  logic              eof_o;
  logic              done_o;
  logic              busy_o;

  modport master (
    output start_i, offset_i, valid_i, sum_i, center_i,
    input  pixel_o, valid_o, eol_o, eof_o, done_o, busy_o
  );

  modport slave (
    input  start_i, offset_i, valid_i, sum_i, center_i,
    output pixel_o, valid_o, eol_o, eof_o, done_o, busy_o
  );
endinterface

// File: rtl/r6_threshold.sv
// Adaptive threshold: compares the window centre against (window mean - C)
// and emits a binary pixel stream with row/frame markers.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting window results until a full frame has been taken
// DRAIN | all inputs taken, waiting for the last output (eof_o)
// DONE  | one-cycle frame-complete pulse on done_o
module r6_threshold #(
  parameter int COLS = 11,
  parameter int ROWS = 11
) (
  input logic           clk,
  input logic           rst_n,
  r6_threshold_if.slave bus
);
  localparam int NPIX = COLS * ROWS;
  localparam int CW   = $clog2(NPIX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic signed [7:0] off_q;
  logic [CW-1:0]     in_cnt, col_cnt, row_cnt;
  logic              s1_v, s2_v;
  logic [15:0]       s1_sum;
  logic [7:0]        s1_ctr, s2_mean, s2_ctr;
  logic [7:0]        pixel_q;
  logic              valid_q, eol_q, eof_q;
  logic              accept, last_col, last_row, pix_hi;
  logic signed [9:0] thr;

  assign accept   = bus.valid_i && (state_q == RUN) && !bus.start_i && (in_cnt < CW'(NPIX));
  assign last_col = (col_cnt == CW'(COLS - 1));
  assign last_row = (row_cnt == CW'(ROWS - 1));

  // Threshold may go negative or above 255, hence the 10-bit signed compare.
  assign thr    = $signed({2'b00, s2_mean}) - $signed({{2{off_q[7]}}, off_q});
  assign pix_hi = $signed({2'b00, s2_ctr}) > thr;

  always_comb begin
    state_d = state_q;
    if (bus.start_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (accept && (in_cnt == CW'(NPIX - 1))) state_d = DRAIN;
        DRAIN:   if (eof_q) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      in_cnt  <= '0;
      col_cnt <= '0;
      row_cnt <= '0;
      s1_v    <= 1'b0;
      s1_sum  <= '0;
      s1_ctr  <= '0;
      s2_v    <= 1'b0;
      s2_mean <= '0;
      s2_ctr  <= '0;
      pixel_q <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.start_i) begin
        off_q   <= bus.offset_i;
        in_cnt  <= '0;
        col_cnt <= '0;
        row_cnt <= '0;
        s1_v    <= 1'b0;
        s2_v    <= 1'b0;
        valid_q <= 1'b0;
        eol_q   <= 1'b0;
        eof_q   <= 1'b0;
      end else begin
        s1_v <= accept;
        if (accept) begin
          s1_sum <= bus.sum_i;
          s1_ctr <= bus.center_i;
          in_cnt <= in_cnt + CW'(1);
        end
        // 388/65536 approximates 1/169; the truncation is intentional.
        s2_v <= s1_v;
        if (s1_v) begin
          s2_mean <= 8'((25'(s1_sum) * 25'd388) >> 16);
          s2_ctr  <= s1_ctr;
        end
        valid_q <= s2_v;
        eol_q   <= s2_v && last_col;
        eof_q   <= s2_v && last_col && last_row;
        if (s2_v) begin
          pixel_q <= pix_hi ? 8'hFF : 8'h00;
          col_cnt <= last_col ? '0 : col_cnt + CW'(1);
          if (last_col) row_cnt <= last_row ? '0 : row_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.pixel_o = pixel_q;
  assign bus.valid_o = valid_q;
  assign bus.eol_o   = eol_q;
  assign bus.eof_o   = eof_q;
  assign bus.done_o  = (state_q == DONE);
  assign bus.busy_o  = (state_q != IDLE);
endmodule

// File: doc/r6_threshold.md
R6_THRESHOLD -- requirements
Module: r6_threshold

Interface
REQ-001 SHALL have parameter COLS, default 11: window results per output row.
REQ-002 SHALL have parameter ROWS, default 11: output rows per frame.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: single-cycle frame start pulse.
REQ-006 SHALL have port offset_i, input, 8 bits, signed: threshold offset C, sampled on start_i.
REQ-007 SHALL have port valid_i, input, 1 bit: qualifies sum_i and center_i.
REQ-008 SHALL have port sum_i, input, 16 bits: 13x13 window sum from the upstream R6 sum stage, range 0..43095.
REQ-009 SHALL have port center_i, input, 8 bits: window central pixel, aligned with sum_i.
REQ-010 SHALL have port pixel_o, output, 8 bits: binarized pixel, either 255 or 0.
REQ-011 SHALL have port valid_o, output, 1 bit: qualifies pixel_o.
REQ-012 SHALL have port eol_o, output, 1 bit: asserted with the last valid_o of each row.
REQ-013 SHALL have port eof_o, output, 1 bit: asserted with the last valid_o of the frame.
REQ-014 SHALL have port done_o, output, 1 bit: one-cycle pulse marking frame completion.
REQ-015 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
  - IDLE->RUN on start_i.
  - RUN->DRAIN after COLS*ROWS accepted inputs.
  - DRAIN->DONE when the eof_o output has been issued.
  - DONE->IDLE unconditionally after 1 cycle.
REQ-017 SHALL accept an input only when valid_i=1 and the FSM is in RUN with fewer than COLS*ROWS inputs accepted; all other valid_i SHALL be ignored (no backpressure, no error flag).
REQ-018 SHALL compute mean = (sum_i * 388) >> 16, using a 25-bit unsigned product and an 8-bit result; the result is exactly this formula, not a true division by 169.
REQ-019 SHALL compute thr = mean - C as 10-bit signed with no clamping, then set pixel_o = 255 if {2'b00,center} > thr (signed compare), else 0.
REQ-020 SHALL use a 3-stage pipeline: input register, multiply, compare/output register; valid_o SHALL follow an accepted input by exactly 3 cycles.
REQ-021 SHALL count emitted outputs with a column counter (0..COLS-1, wrapping) and a row counter (0..ROWS-1).
  - eol_o is set when the column counter = COLS-1.
  - eof_o is set on output number COLS*ROWS.
REQ-022 SHALL assert done_o in the cycle after eof_o and return the FSM to IDLE one cycle later.
REQ-023 SHALL treat start_i in RUN or DRAIN as a restart: clear the counters, invalidate all in-flight pipeline stages, resample offset_i and enter RUN; start_i in DONE SHALL likewise enter RUN.
REQ-024 SHALL hold pixel_o at its last value while valid_o=0; eol_o, eof_o and done_o SHALL be low whenever they are not being asserted.

Reset
REQ-025 SHALL, while rst_n=0, force the following immediately and asynchronously:
  - FSM to IDLE; all counters, pipeline valids and registered C to 0.
  - pixel_o=0, valid_o=0, eol_o=0, eof_o=0, done_o=0, busy_o=0.
REQ-026 SHALL, when rst_n is asserted mid-frame, discard the frame; after release the block SHALL stay in IDLE until start_i.

Verification
REQ-027 SHALL be tested with C=0; sum=16900, center=101 -> mean 100, pixel_o=255 three cycles later; center=100 -> pixel_o=0.
REQ-028 SHALL be tested with these boundary cases:
  - C=0, sum=43095, center=255 -> pixel_o=0.
  - C=5, sum=0, center=0 -> pixel_o=255 (thr -5).
  - C=-10, sum=43095, center=255 -> pixel_o=0 (thr 265).
REQ-029 SHALL be tested with a full frame at COLS=ROWS=11 (121 contiguous valid_i), requiring:
  - eol_o on outputs 11, 22, ..., 121.
  - eof_o on output 121 only; done_o one cycle later; busy_o low after DONE.
  - a 122nd valid_i ignored.
REQ-030 SHALL be tested with valid_i pulsed every 3rd cycle, plus 5 valid_i pulses while in IDLE -> identical pixel sequence to the contiguous case, and the IDLE inputs produce no output.
REQ-031 SHALL be tested with start_i after 50 inputs -> in-flight outputs suppressed, counters restart, and the following 121 inputs produce a complete frame with the new C.
REQ-032 SHALL be tested with rst_n low for 1 cycle mid-frame -> all outputs 0 immediately, FSM in IDLE, and valid_i ignored until start_i.
